// File: rtl/pq_pkg.sv
// Shared types for the register-array priority queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// kv_t is the queued item. Only the key is ever compared, as unsigned.
// pq_op_t is the operation latched at acceptance.
// pq_sel_t is the per-cell source select.
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        ENQ  = 2'd0,
        DEQ  = 2'd1,
        REPL = 2'd2
    } pq_op_t;

    // Code 2'b11 is never generated and decodes the same as SEL_NBR.
    typedef logic [1:0] pq_sel_t;
    localparam pq_sel_t SEL_HOLD = 2'b00;
    localparam pq_sel_t SEL_NEW  = 2'b01;
    localparam pq_sel_t SEL_NBR  = 2'b10;

endpackage

// File: rtl/ra_pq_cell.sv
// One priority-queue array cell: a kv_t register with a 3-way source select.
// Latency: 1 cycle from select to register update.
// Backpressure: none; the cell follows its select code every cycle.
//
// Ports: clk, rst (sync, active-high, clears to '0), sel (hold/new/neighbour),
//        new_kv (item being inserted), nbr_kv (already-muxed neighbour),
//        cell_kv (current contents, also the hold source).
module ra_pq_cell
    import pq_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  pq_sel_t sel,
    input  kv_t     new_kv,
    input  kv_t     nbr_kv,
    output kv_t     cell_kv
);

    kv_t kv_q;
    kv_t kv_d;

    always_comb begin
        kv_d = kv_q;
        case (sel)
            SEL_HOLD: kv_d = kv_q;
            SEL_NEW:  kv_d = new_kv;
            default:  kv_d = nbr_kv;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kv_q <= '0;
        end else begin
            kv_q <= kv_d;
        end
    end

    assign cell_kv = kv_q;

endmodule

// File: rtl/ra_pq_ctrl.sv
// Register-array priority queue controller: DEPTH sorted cells, minimum key at cell 0.
// Latency: accept at edge T, array/count updated at edge T+1; one operation per 2 cycles.
// Backpressure: both readies are low in SHIFT; enq_ready low when full (unless replacing).
//
// Ports: clk, rst (sync active-high); enq_valid/enq_kv/enq_ready insert;
//        deq_valid/deq_ready pop, deq_kv = head (cell 0); count/empty/full status;
//        busy = FSM in SHIFT.
// Build option RA_PQ_REPLACE_EN: a simultaneous enq+deq on a non-empty queue becomes
// one REPL operation. Without it the dequeue wins and the enqueue waits for a later IDLE.
module ra_pq_ctrl
    import pq_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_valid,
    input  kv_t           enq_kv,
    output logic          enq_ready,
    input  logic          deq_valid,
    output logic          deq_ready,
    output kv_t           deq_kv,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    pq_op_t        op_q, op_d;
    logic [CW-1:0] pos_q, pos_d;
    logic [CW-1:0] count_q, count_d;
    kv_t           new_kv_q, new_kv_d;

    kv_t           cell_kv [DEPTH];
    kv_t           nbr_kv  [DEPTH];
    pq_sel_t       sel     [DEPTH];

    logic [CW-1:0] pos_c;
    logic          enq_acc;
    logic          deq_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign busy   = (state_q == SHIFT);
    assign count  = count_q;
    assign deq_kv = cell_kv[0];

    // Insert position: number of valid cells whose key is <= the new key, so
    // equal keys land behind existing ones and pop in arrival order.
    always_comb begin
        pos_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (cell_kv[i].key <= enq_kv.key)) begin
                pos_c = pos_c + CW'(1);
            end
        end
    end

    always_comb begin
        enq_ready = 1'b0;
        deq_ready = 1'b0;
        if (state_q == IDLE) begin
            deq_ready = !empty;
`ifdef RA_PQ_REPLACE_EN
            // When full, a concurrent dequeue frees the slot the insert needs.
            enq_ready = !full || deq_valid;
`else
            enq_ready = !full && !(deq_valid && !empty);
`endif
        end
    end

    assign enq_acc = enq_valid && enq_ready;
    assign deq_acc = deq_valid && deq_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pos_d    = pos_q;
        count_d  = count_q;
        new_kv_d = new_kv_q;
        case (state_q)
            IDLE: begin
                if (enq_acc || deq_acc) begin
                    state_d  = SHIFT;
                    pos_d    = pos_c;
                    new_kv_d = enq_kv;
`ifdef RA_PQ_REPLACE_EN
                    if (enq_acc && deq_acc) begin
                        op_d = REPL;
                    end else
`endif
                    if (enq_acc) begin
                        op_d = ENQ;
                    end else begin
                        op_d = DEQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                case (op_q)
                    ENQ:     count_d = count_q + CW'(1);
                    DEQ:     count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        endcase
    end

`ifdef RA_PQ_REPLACE_EN
    // Head leaves while the new item goes in: its slot shifts down by one,
    // clamped to cell 0 when the new key is below the current head.
    logic [CW-1:0] repl_p;
    assign repl_p = (pos_q == '0) ? '0 : (pos_q - CW'(1));
`endif

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = SEL_HOLD;
            if (state_q == SHIFT) begin
                case (op_q)
                    ENQ: begin
                        if (CW'(i) < pos_q) begin
                            sel[i] = SEL_HOLD;
                        end else if (CW'(i) == pos_q) begin
                            sel[i] = SEL_NEW;
                        end else begin
                            sel[i] = SEL_NBR;
                        end
                    end
                    DEQ: begin
                        sel[i] = (i < DEPTH - 1) ? SEL_NBR : SEL_HOLD;
                    end
`ifdef RA_PQ_REPLACE_EN
                    REPL: begin
                        if (CW'(i) < repl_p) begin
                            sel[i] = SEL_NBR;
                        end else if (CW'(i) == repl_p) begin
                            sel[i] = SEL_NEW;
                        end else begin
                            sel[i] = SEL_HOLD;
                        end
                    end
`endif
                    default: sel[i] = SEL_HOLD;
                endcase
            end
        end
    end

    // Neighbour is the cell below for ENQ (shift up) and the cell above for
    // DEQ/REPL (shift down). Edge cells never select a missing neighbour, so
    // they feed back their own value there.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        if (g == 0) begin : g_lo
            assign nbr_kv[g] = (op_q == ENQ) ? cell_kv[g] : cell_kv[g+1];
        end else if (g == DEPTH - 1) begin : g_hi
            assign nbr_kv[g] = (op_q == ENQ) ? cell_kv[g-1] : cell_kv[g];
        end else begin : g_mid
            assign nbr_kv[g] = (op_q == ENQ) ? cell_kv[g-1] : cell_kv[g+1];
        end

        ra_pq_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .sel     (sel[g]),
            .new_kv  (new_kv_q),
            .nbr_kv  (nbr_kv[g]),
            .cell_kv (cell_kv[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= ENQ;
            pos_q    <= '0;
            count_q  <= '0;
            new_kv_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pos_q    <= pos_d;
            count_q  <= count_d;
            new_kv_q <= new_kv_d;
        end
    end

endmodule

// File: doc/ra_pq_ctrl.md
# ra_pq_ctrl

Register-array priority-queue controller for the HWPQ study. It owns a DEPTH-entry sorted array of `kv_t` items, with the minimum key at cell 0. It accepts enqueue and dequeue requests through valid/ready handshakes and sequences each array cell through a per-cell 3-way source select: hold, load new item, or take a neighbour. It is the top of the register-array PQ and is the unit the benchmark harness drives.

## Interface
- `DEPTH`, 8: number of array cells; must be ≥ 2.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enq_valid` input 1: enqueue request.
- `enq_kv` input `kv_t`: item to insert; must be held stable while `enq_valid` is high.
- `enq_ready` output 1: enqueue can be accepted this cycle.
- `deq_valid` input 1: dequeue (pop head) request.
- `deq_ready` output 1: dequeue can be accepted this cycle.
- `deq_kv` output `kv_t`: current head (cell 0); meaningful when `empty` is 0.
- `count` output `$clog2(DEPTH+1)`: number of valid entries.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == DEPTH`.
- `busy` output 1: FSM is in SHIFT.

## Operation
- Invariant: cells `0..count-1` are valid and sorted with non-decreasing key. Cells at or above `count` are don't-care.
- FSM has two states, IDLE and SHIFT.
  - Requests are accepted only in IDLE. A request is accepted when `valid && ready`.
  - Any acceptance moves IDLE → SHIFT.
  - SHIFT always returns to IDLE on the next edge.
- Ready rules (both ready outputs are 0 in SHIFT):
  - In IDLE, `enq_ready = !full`, or 1 when `full && deq_valid` and replace is compiled in.
  - In IDLE, `deq_ready = !empty`.
- Insert position `pos` = number of valid cells with key ≤ `enq_kv.key`. It is computed combinationally in IDLE and registered at acceptance. Equal keys therefore leave FIFO order.
- At acceptance the block also registers the operation code (ENQ, DEQ, REPL) and `enq_kv`.
- Per-cell select codes, applied in SHIFT. Code 00 holds the cell, 01 loads the new item, and 10 takes the neighbour. Code 11 decodes identically to 10 and is never generated.
  - ENQ: `i < pos` → hold; `i == pos` → load; `i > pos` → take cell `i-1`.
  - DEQ: `i < DEPTH-1` → take cell `i+1`; cell `DEPTH-1` → hold.
  - REPL: let `p = max(pos-1, 0)`. `i < p` → take cell `i+1`; `i == p` → load; `i > p` → hold.
- Count update at the end of SHIFT: ENQ +1, DEQ −1, REPL unchanged.
- Simultaneous `enq_valid` and `deq_valid` in IDLE:
  - With REPL compiled in and not empty, both are accepted as one REPL.
  - When empty, only the enqueue is accepted; the dequeue waits for the next IDLE.
  - Without REPL, see Configuration.
- Key comparison is unsigned, at `KEY_WIDTH` bits. The value field is never compared.

## Timing
- Reset (edge with `rst == 1`) produces:
  - state IDLE, `count` 0, `empty` 1, `full` 0, `busy` 0.
  - all cells cleared to `'0`, so `deq_kv` reads `'0`.
  - `deq_ready` 0 and `enq_ready` 1 in the first cycle after reset.
- Reset has priority over everything. If asserted during SHIFT, the in-flight operation is abandoned and no cell is updated except the clear.
- Accept at edge T. SHIFT occupies cycle T..T+1. Array and `count` are updated at edge T+1. The new head is visible on `deq_kv` from T+1.
- `deq_kv` sampled in the accept cycle is the popped item.
- Throughput is one operation per 2 cycles.
- Full or empty boundaries:
  - ENQ with `full` is never accepted.
  - REPL with `full` keeps `count == DEPTH`.
  - DEQ taking `count` 1 → 0 asserts `empty` at T+1.

## Configuration
- `RA_PQ_REPLACE_EN` defined:
  - REPL is supported.
  - A simultaneous request is a single 2-cycle operation.
  - `enq_ready` may be 1 while `full` (only when `deq_valid` is also high).
- `RA_PQ_REPLACE_EN` undefined:
  - REPL logic is absent.
  - On a simultaneous request, the dequeue has priority: `enq_ready = 0` whenever `deq_valid && !empty`.
  - The enqueue is accepted in a later IDLE.

## Structure
- `pq_pkg` supplies `kv_t`, `KEY_WIDTH` and `VAL_WIDTH`.
- New additions to `pq_pkg`:
  - `pq_op_t` enum: ENQ, DEQ, REPL.
  - `pq_sel_t` 2-bit select encoding with constants SEL_HOLD, SEL_NEW, SEL_NBR.
- One sub-module, `ra_pq_cell`. It contains one `kv_t` register plus its 3-way select.
  - Inputs: own value, new item, neighbour item, select, `clk`, `rst`.
  - It is instantiated DEPTH times in a generate loop.
  - The neighbour input is muxed by op: `i-1` for ENQ, `i+1` for DEQ/REPL.
- FSM, `pos` computation and select generation live in `ra_pq_ctrl`.

## Test plan
- Reset, then enqueue keys 5, 2, 9, 2 (values 1, 2, 3, 4).
  - Required: `count` 4.
  - Required: pops return key/value pairs (2,2), (2,4), (5,1), (9,3), then `empty` 1.
- Fill all 8 cells.
  - Required: `full` 1 and `enq_ready` 0 (with `deq_valid` low).
  - Required: a 9th enqueue is held off until a dequeue completes.
- With `RA_PQ_REPLACE_EN`, queue {3, 7}, simultaneous enq key 4 and deq.
  - Required: `deq_kv` shows 3 in the accept cycle.
  - Required: array {4, 7} and `count` 2 two cycles later.
- Without `RA_PQ_REPLACE_EN`, same stimulus.
  - Required: DEQ first, then ENQ.
  - Required: final array {4, 7}, and 4 cycles elapse.
- Empty queue, `deq_valid` and `enq_valid` both high with key 6.
  - Required: ENQ accepted.
  - Required: the next IDLE accepts the DEQ, which returns 6.
- Assert `rst` during SHIFT of an enqueue.
  - Required: next cycle `count` 0, `empty` 1, `deq_kv` `'0`, `busy` 0.
